// File: rtl/lcd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_ctrl
//  Purpose  : HD44780-style character LCD write controller. After power-on it
//             runs a fixed four-byte init sequence (0x38, 0x0C, 0x01, 0x06),
//             then accepts single-byte command/data writes through a
//             valid/ready handshake. Each byte goes through setup, enable
//             pulse, hold and post-write busy-wait phases, all timed by one
//             shared down-counter.
//  Ports    : i_clk        - rising-edge clock
//             i_rst        - synchronous active-high reset
//             i_req_vld    - request valid
//             i_req_rs     - 0 = command byte, 1 = data byte
//             i_req_data   - byte to write
//             o_req_rdy    - request accepted on this cycle's rising edge
//             o_busy       - controller not idle
//             o_init_done  - power-on init complete (sticky until reset)
//             o_io_lcd     - [31]=ON [10]=EN [9]=RS [8]=RW [7:0]=DATA
//  Revision : 1.0 - initial release
// ============================================================================
module lcd_ctrl #(
    parameter int PWR_CYC   = 750000,
    parameter int SETUP_CYC = 4,
    parameter int EN_CYC    = 12,
    parameter int HOLD_CYC  = 4,
    parameter int CMD_CYC   = 2000,
    parameter int CLR_CYC   = 82000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_vld,
    input  logic        i_req_rs,
    input  logic [7:0]  i_req_data,
    output logic        o_req_rdy,
    output logic        o_busy,
    output logic        o_init_done,
    output logic [31:0] o_io_lcd
);

    // Counter width: wide enough for the longest duration, never below 20 bits.
    localparam int c_max_a = (PWR_CYC > CLR_CYC) ? PWR_CYC : CLR_CYC;
    localparam int c_max_b = (CMD_CYC > EN_CYC) ? CMD_CYC : EN_CYC;
    localparam int c_max_c = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
    localparam int c_max_ab = (c_max_a > c_max_b) ? c_max_a : c_max_b;
    localparam int c_max = (c_max_ab > c_max_c) ? c_max_ab : c_max_c;
    localparam int c_need = $clog2(c_max + 1);
    localparam int c_cnt_w = (c_need > 20) ? c_need : 20;

    localparam logic [c_cnt_w-1:0] c_pwr_ld   = c_cnt_w'(PWR_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_setup_ld = c_cnt_w'(SETUP_CYC - 1);
    // LOAD already presents the byte for one cycle, so it serves as the first
    // setup cycle; the SETUP state that follows only covers the remainder.
    localparam logic [c_cnt_w-1:0] c_setup_after_load_ld =
        c_cnt_w'((SETUP_CYC > 1) ? (SETUP_CYC - 2) : 0);
    localparam logic [c_cnt_w-1:0] c_en_ld    = c_cnt_w'(EN_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_hold_ld  = c_cnt_w'(HOLD_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_cmd_ld   = c_cnt_w'(CMD_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_clr_ld   = c_cnt_w'(CLR_CYC - 1);

    localparam logic [2:0] c_s_pwr_wait = 3'd0;
    localparam logic [2:0] c_s_load     = 3'd1;
    localparam logic [2:0] c_s_setup    = 3'd2;
    localparam logic [2:0] c_s_en_hi    = 3'd3;
    localparam logic [2:0] c_s_hold     = 3'd4;
    localparam logic [2:0] c_s_wait     = 3'd5;
    localparam logic [2:0] c_s_idle     = 3'd6;

    logic [2:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [1:0]         r_idx;
    logic               r_init_done;
    logic               r_rs;
    logic [7:0]         r_data;

    logic [2:0]         w_state_nxt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [1:0]         w_idx_nxt;
    logic               w_init_done_nxt;
    logic               w_rs_nxt;
    logic [7:0]         w_data_nxt;
    logic               w_zero;

    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    init_byte = 8'h38;
            2'd1:    init_byte = 8'h0C;
            2'd2:    init_byte = 8'h01;
            default: init_byte = 8'h06;
        endcase
    endfunction

    // Clear (0x01) and return-home (0x02) commands need the long busy wait.
    function automatic logic [c_cnt_w-1:0] wait_ld(input logic rs, input logic [7:0] d);
        if (!rs && ((d == 8'h01) || (d == 8'h02))) wait_ld = c_clr_ld;
        else                                       wait_ld = c_cmd_ld;
    endfunction

    assign w_zero = (r_cnt == '0);

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = w_zero ? r_cnt : (r_cnt - c_cnt_w'(1));
        w_idx_nxt       = r_idx;
        w_init_done_nxt = r_init_done;
        w_rs_nxt        = r_rs;
        w_data_nxt      = r_data;

        case (r_state)
            c_s_pwr_wait: begin
                if (w_zero) begin
                    w_state_nxt = c_s_load;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = 2'd0;
                    w_rs_nxt    = 1'b0;
                    w_data_nxt  = init_byte(2'd0);
                end
            end
            c_s_load: begin
                if (SETUP_CYC > 1) begin
                    w_state_nxt = c_s_setup;
                    w_cnt_nxt   = c_setup_after_load_ld;
                end else begin
                    w_state_nxt = c_s_en_hi;
                    w_cnt_nxt   = c_en_ld;
                end
            end
            c_s_setup: begin
                if (w_zero) begin
                    w_state_nxt = c_s_en_hi;
                    w_cnt_nxt   = c_en_ld;
                end
            end
            c_s_en_hi: begin
                if (w_zero) begin
                    w_state_nxt = c_s_hold;
                    w_cnt_nxt   = c_hold_ld;
                end
            end
            c_s_hold: begin
                if (w_zero) begin
                    w_state_nxt = c_s_wait;
                    w_cnt_nxt   = wait_ld(r_rs, r_data);
                end
            end
            c_s_wait: begin
                if (w_zero) begin
                    w_cnt_nxt = '0;
                    if (!r_init_done && (r_idx != 2'd3)) begin
                        w_state_nxt = c_s_load;
                        w_idx_nxt   = r_idx + 2'd1;
                        w_rs_nxt    = 1'b0;
                        w_data_nxt  = init_byte(r_idx + 2'd1);
                    end else begin
                        w_state_nxt     = c_s_idle;
                        w_init_done_nxt = 1'b1;
                    end
                end
            end
            c_s_idle: begin
                if (i_req_vld && r_init_done) begin
                    w_state_nxt = c_s_setup;
                    w_cnt_nxt   = c_setup_ld;
                    w_rs_nxt    = i_req_rs;
                    w_data_nxt  = i_req_data;
                end
            end
            default: begin
                w_state_nxt = c_s_pwr_wait;
                w_cnt_nxt   = c_pwr_ld;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= c_s_pwr_wait;
            r_cnt       <= c_pwr_ld;
            r_idx       <= 2'd0;
            r_init_done <= 1'b0;
            r_rs        <= 1'b0;
            r_data      <= 8'h00;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_init_done <= w_init_done_nxt;
            r_rs        <= w_rs_nxt;
            r_data      <= w_data_nxt;
        end
    end

    assign o_busy      = (r_state != c_s_idle);
    assign o_req_rdy   = (r_state == c_s_idle) && r_init_done;
    assign o_init_done = r_init_done;
    // ON follows reset directly so the panel is powered in every non-reset cycle,
    // including the first cycle after reset is released.
    assign o_io_lcd    = {~i_rst, 20'd0, (r_state == c_s_en_hi), r_rs, 1'b0, r_data};

endmodule
`default_nettype wire
